// File: rtl/binary_op_if.sv
// Valid/ready transaction bundle for binary_op_unit: operands and opcode in, result and err out.
interface binary_op_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             err;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, err
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, err
   );
endinterface

// File: rtl/binary_op_unit.sv
// Registered two-operand operator unit. Single-cycle ops load the output register directly;
// DIV/MOD run a restoring divider on operand magnitudes, one quotient bit per cycle.
module binary_op_unit #(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input logic        clk,
   input logic        rst_n,
   binary_op_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [4:0] OP_AND  = 5'd0;
   localparam logic [4:0] OP_OR   = 5'd1;
   localparam logic [4:0] OP_XOR  = 5'd2;
   localparam logic [4:0] OP_XNOR = 5'd3;
   localparam logic [4:0] OP_SHL  = 5'd4;
   localparam logic [4:0] OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SSHL = 5'd6;
   localparam logic [4:0] OP_SSHR = 5'd7;
   localparam logic [4:0] OP_LAND = 5'd8;
   localparam logic [4:0] OP_LOR  = 5'd9;
   localparam logic [4:0] OP_EQX  = 5'd10;
   localparam logic [4:0] OP_NEX  = 5'd11;
   localparam logic [4:0] OP_LT   = 5'd12;
   localparam logic [4:0] OP_LE   = 5'd13;
   localparam logic [4:0] OP_EQ   = 5'd14;
   localparam logic [4:0] OP_NE   = 5'd15;
   localparam logic [4:0] OP_GE   = 5'd16;
   localparam logic [4:0] OP_GT   = 5'd17;
   localparam logic [4:0] OP_ADD  = 5'd18;
   localparam logic [4:0] OP_SUB  = 5'd19;
   localparam logic [4:0] OP_MUL  = 5'd20;
   localparam logic [4:0] OP_DIV  = 5'd21;
   localparam logic [4:0] OP_MOD  = 5'd22;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DIV = 1'b1} state_t;

   function automatic logic [WIDTH-1:0] zext(input logic bit_v);
      return {{(WIDTH-1){1'b0}}, bit_v};
   endfunction

   state_t           state_r;
   logic             out_valid_r;
   logic             err_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] divisor_r;
   logic [CW-1:0]    cnt_r;
   logic             neg_q_r;
   logic             neg_rem_r;
   logic             is_mod_r;

   logic             accept_s;
   logic             b_zero_s;
   logic             start_div_s;
   logic             lt_s;
   logic             eq_s;
   logic [WIDTH-1:0] asr_s;
   logic [WIDTH-1:0] single_res_s;
   logic             single_err_s;
   logic             sign_a_s;
   logic             sign_b_s;
   logic [WIDTH-1:0] mag_a_s;
   logic [WIDTH-1:0] mag_b_s;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH:0]   diff_s;
   logic             step_ge_s;
   logic [WIDTH-1:0] step_rem_s;
   logic [WIDTH-1:0] step_quo_s;
   logic [WIDTH-1:0] div_res_s;

   assign bus.in_ready  = rst_n & (state_r == ST_IDLE) & (~out_valid_r | bus.out_ready);
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.err       = err_r;

   assign accept_s    = bus.in_valid & bus.in_ready;
   assign b_zero_s    = (bus.b == {WIDTH{1'b0}});
   assign start_div_s = accept_s & ((bus.op == OP_DIV) | (bus.op == OP_MOD)) & ~b_zero_s;

   // Standalone so the arithmetic shift keeps its signed context.
   assign asr_s = $signed(bus.a) >>> bus.b;
   assign eq_s  = (bus.a == bus.b);

   // Ordering compare, signed or unsigned by parameter.
   always_comb begin
      lt_s = 1'b0;
      if (SIGNED) begin
         lt_s = $signed(bus.a) < $signed(bus.b);
      end else begin
         lt_s = bus.a < bus.b;
      end
   end

   // Result of every opcode that completes in one cycle, including DIV/MOD by zero.
   always_comb begin
      single_res_s = {WIDTH{1'b0}};
      single_err_s = 1'b0;
      case (bus.op)
         OP_AND:          single_res_s = bus.a & bus.b;
         OP_OR:           single_res_s = bus.a | bus.b;
         OP_XOR:          single_res_s = bus.a ^ bus.b;
         OP_XNOR:         single_res_s = ~(bus.a ^ bus.b);
         OP_SHL, OP_SSHL: single_res_s = bus.a << bus.b;
         OP_SHR:          single_res_s = bus.a >> bus.b;
         OP_SSHR:         single_res_s = SIGNED ? asr_s : (bus.a >> bus.b);
         OP_LAND:         single_res_s = zext((|bus.a) & (|bus.b));
         OP_LOR:          single_res_s = zext((|bus.a) | (|bus.b));
         OP_EQX:          single_res_s = zext(bus.a === bus.b);
         OP_NEX:          single_res_s = zext(bus.a !== bus.b);
         OP_LT:           single_res_s = zext(lt_s);
         OP_LE:           single_res_s = zext(lt_s | eq_s);
         OP_EQ:           single_res_s = zext(eq_s);
         OP_NE:           single_res_s = zext(~eq_s);
         OP_GE:           single_res_s = zext(~lt_s);
         OP_GT:           single_res_s = zext(~(lt_s | eq_s));
         OP_ADD:          single_res_s = bus.a + bus.b;
         OP_SUB:          single_res_s = bus.a - bus.b;
         OP_MUL:          single_res_s = bus.a * bus.b;
         OP_DIV: begin
            single_res_s = {WIDTH{1'b1}};
            single_err_s = 1'b1;
         end
         OP_MOD: begin
            single_res_s = bus.a;
            single_err_s = 1'b1;
         end
         default: begin
            single_res_s = {WIDTH{1'b0}};
            single_err_s = 1'b1;
         end
      endcase
   end

   assign sign_a_s = SIGNED & bus.a[WIDTH-1];
   assign sign_b_s = SIGNED & bus.b[WIDTH-1];
   assign mag_a_s  = sign_a_s ? ({WIDTH{1'b0}} - bus.a) : bus.a;
   assign mag_b_s  = sign_b_s ? ({WIDTH{1'b0}} - bus.b) : bus.b;

   // One restoring-division step; the borrow of the trial subtraction decides the quotient bit.
   always_comb begin
      trial_s    = {rem_r, quo_r[WIDTH-1]};
      diff_s     = trial_s - {1'b0, divisor_r};
      step_ge_s  = ~diff_s[WIDTH];
      step_quo_s = {quo_r[WIDTH-2:0], step_ge_s};
      if (step_ge_s) begin
         step_rem_s = diff_s[WIDTH-1:0];
      end else begin
         step_rem_s = trial_s[WIDTH-1:0];
      end
      if (is_mod_r) begin
         div_res_s = neg_rem_r ? ({WIDTH{1'b0}} - step_rem_s) : step_rem_s;
      end else begin
         div_res_s = neg_q_r ? ({WIDTH{1'b0}} - step_quo_s) : step_quo_s;
      end
   end

   // Control FSM, divider datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         out_valid_r <= 1'b0;
         err_r       <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         rem_r       <= {WIDTH{1'b0}};
         quo_r       <= {WIDTH{1'b0}};
         divisor_r   <= {WIDTH{1'b0}};
         cnt_r       <= {CW{1'b0}};
         neg_q_r     <= 1'b0;
         neg_rem_r   <= 1'b0;
         is_mod_r    <= 1'b0;
      end else begin
         if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (start_div_s) begin
                  state_r   <= ST_DIV;
                  rem_r     <= {WIDTH{1'b0}};
                  quo_r     <= mag_a_s;
                  divisor_r <= mag_b_s;
                  cnt_r     <= {CW{1'b0}};
                  neg_q_r   <= sign_a_s ^ sign_b_s;
                  neg_rem_r <= sign_a_s;
                  is_mod_r  <= (bus.op == OP_MOD);
               end else if (accept_s) begin
                  result_r    <= single_res_s;
                  err_r       <= single_err_s;
                  out_valid_r <= 1'b1;
               end
            end
            ST_DIV: begin
               rem_r <= step_rem_s;
               quo_r <= step_quo_s;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CNT_LAST) begin
                  result_r    <= div_res_s;
                  err_r       <= 1'b0;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_binary_op_unit.sv
// Drives an unsigned and a signed binary_op_unit with identical stimulus and checks both
// against an integer-arithmetic reference model.
module tb_binary_op_unit;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic [4:0] op;
   logic [7:0] a;
   logic [7:0] b;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] last_res_u, last_res_s;
   logic       last_err_u, last_err_s;

   always #5 clk = ~clk;

   binary_op_if #(.WIDTH(8)) bus_u ();
   binary_op_if #(.WIDTH(8)) bus_s ();

   assign bus_u.in_valid  = in_valid;
   assign bus_u.op        = op;
   assign bus_u.a         = a;
   assign bus_u.b         = b;
   assign bus_u.out_ready = out_ready;
   assign bus_s.in_valid  = in_valid;
   assign bus_s.op        = op;
   assign bus_s.a         = a;
   assign bus_s.b         = b;
   assign bus_s.out_ready = out_ready;

   binary_op_unit #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));
   binary_op_unit #(.WIDTH(8), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: operators evaluated on plain ints, result is the low 8 bits.
   function automatic void model(input logic [4:0] m_op, input logic [7:0] m_a, input logic [7:0] m_b,
                                 input bit sgn, output logic [7:0] m_res, output logic m_err);
      int ua, ub, sa, sb, r;
      ua = int'(m_a);
      ub = int'(m_b);
      sa = (sgn && m_a[7]) ? ua - 256 : ua;
      sb = (sgn && m_b[7]) ? ub - 256 : ub;
      r = 0;
      m_err = 1'b0;
      case (m_op)
         5'd0:  r = ua & ub;
         5'd1:  r = ua | ub;
         5'd2:  r = ua ^ ub;
         5'd3:  r = ~(ua ^ ub);
         5'd4, 5'd6: r = (ub >= 8) ? 0 : ua * (1 << ub);
         5'd5:  r = (ub >= 8) ? 0 : ua / (1 << ub);
         5'd7: begin
            if (sgn) r = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
            else     r = (ub >= 8) ? 0 : ua / (1 << ub);
         end
         5'd8:  r = int'(ua != 0 && ub != 0);
         5'd9:  r = int'(ua != 0 || ub != 0);
         5'd10, 5'd14: r = int'(ua == ub);
         5'd11, 5'd15: r = int'(ua != ub);
         5'd12: r = int'(sa < sb);
         5'd13: r = int'(sa <= sb);
         5'd16: r = int'(sa >= sb);
         5'd17: r = int'(sa > sb);
         5'd18: r = ua + ub;
         5'd19: r = ua - ub;
         5'd20: r = ua * ub;
         5'd21: begin
            if (ub == 0) begin r = 255; m_err = 1'b1; end
            else r = sa / sb;
         end
         5'd22: begin
            if (ub == 0) begin r = ua; m_err = 1'b1; end
            else r = sa % sb;
         end
         default: begin r = 0; m_err = 1'b1; end
      endcase
      m_res = r[7:0];
   endfunction

   // One transaction from a negedge; optional output stall of 'hold' cycles.
   task automatic run_txn(input logic [4:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b, input int hold);
      logic [7:0] eu, es;
      logic       erru, errs;
      int lat, rdy_low, exp_lat;
      model(t_op, t_a, t_b, 1'b0, eu, erru);
      model(t_op, t_a, t_b, 1'b1, es, errs);
      exp_lat = ((t_op == 5'd21 || t_op == 5'd22) && t_b != 8'd0) ? 9 : 1;
      op = t_op; a = t_a; b = t_b; in_valid = 1'b1; out_ready = (hold == 0);
      #1;
      check_val("in_ready_start", {31'd0, bus_u.in_ready & bus_s.in_ready}, 32'd1);
      lat = 0; rdy_low = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         lat++;
         if (lat == 1) begin
            #1;
            in_valid = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
         end
         @(negedge clk);
         if (bus_u.out_valid) break;
         if (!bus_u.in_ready) rdy_low++;
      end
      check_val("latency", lat, exp_lat);
      check_val("busy_cycles", rdy_low, exp_lat - 1);
      check_val("valid_s", {31'd0, bus_s.out_valid}, 32'd1);
      check_val("result_u", {24'd0, bus_u.result}, {24'd0, eu});
      check_val("err_u", {31'd0, bus_u.err}, {31'd0, erru});
      check_val("result_s", {24'd0, bus_s.result}, {24'd0, es});
      check_val("err_s", {31'd0, bus_s.err}, {31'd0, errs});
      last_res_u = bus_u.result; last_err_u = bus_u.err;
      last_res_s = bus_s.result; last_err_s = bus_s.err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_val("hold_valid", {31'd0, bus_u.out_valid}, 32'd1);
         check_val("hold_result", {24'd0, bus_u.result}, {24'd0, eu});
         check_val("hold_ready", {31'd0, bus_u.in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_val("drained", {31'd0, bus_u.out_valid | bus_s.out_valid}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] eu, es;
      logic       erru, errs;
      logic [4:0] r_op;
      logic [7:0] r_a, r_b;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 5'd0; a = 8'd0; b = 8'd0;
      @(negedge clk);
      @(negedge clk);
      check_val("rst_valid", {31'd0, bus_u.out_valid}, 32'd0);
      check_val("rst_result", {24'd0, bus_u.result}, 32'd0);
      check_val("rst_err", {31'd0, bus_u.err}, 32'd0);
      check_val("rst_in_ready", {31'd0, bus_u.in_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      check_val("post_rst_ready", {31'd0, bus_u.in_ready}, 32'd1);
      @(negedge clk);

      // Back-to-back sweep of single-cycle ops: one result per cycle.
      for (int i = 0; i <= 21; i++) begin
         if (i > 0) begin
            model(5'(i - 1), 8'hA5, 8'h03, 1'b0, eu, erru);
            model(5'(i - 1), 8'hA5, 8'h03, 1'b1, es, errs);
            check_val("sweep_valid", {31'd0, bus_u.out_valid}, 32'd1);
            check_val("sweep_u", {24'd0, bus_u.result}, {24'd0, eu});
            check_val("sweep_s", {24'd0, bus_s.result}, {24'd0, es});
            case (i - 1)
               0:  check_val("spec_and", {24'd0, bus_u.result}, 32'h01);
               4:  check_val("spec_shl", {24'd0, bus_u.result}, 32'h28);
               12: check_val("spec_lt", {24'd0, bus_u.result}, 32'h00);
               18: check_val("spec_add", {24'd0, bus_u.result}, 32'hA8);
               20: check_val("spec_mul", {24'd0, bus_u.result}, 32'hEF);
               default: ;
            endcase
         end
         if (i <= 20) begin
            op = 5'(i); a = 8'hA5; b = 8'h03; in_valid = 1'b1;
            #1;
            check_val("sweep_ready", {31'd0, bus_u.in_ready}, 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      check_val("sweep_idle", {31'd0, bus_u.out_valid}, 32'd0);

      run_txn(5'd21, 8'd200, 8'd7, 0);
      check_val("spec_div", {24'd0, last_res_u}, 32'd28);
      run_txn(5'd22, 8'd200, 8'd7, 0);
      check_val("spec_mod", {24'd0, last_res_u}, 32'd4);
      check_val("spec_mod_err", {31'd0, last_err_u}, 32'd0);
      run_txn(5'd21, 8'h55, 8'h00, 0);
      check_val("spec_div0", {23'd0, last_err_u, last_res_u}, 32'h1FF);
      run_txn(5'd22, 8'h55, 8'h00, 0);
      check_val("spec_mod0", {23'd0, last_err_u, last_res_u}, 32'h155);
      run_txn(5'd7, 8'h90, 8'd9, 0);
      check_val("spec_sshr_s", {24'd0, last_res_s}, 32'hFF);
      run_txn(5'd21, 8'hF9, 8'd2, 0);
      check_val("spec_sdiv", {24'd0, last_res_s}, 32'hFD);
      run_txn(5'd22, 8'hF9, 8'd2, 0);
      check_val("spec_smod", {24'd0, last_res_s}, 32'hFF);
      run_txn(5'd12, 8'hFF, 8'd1, 0);
      check_val("spec_slt", {24'd0, last_res_s}, 32'h01);
      run_txn(5'd21, 8'h80, 8'hFF, 0);
      check_val("spec_minneg_div", {23'd0, last_err_s, last_res_s}, 32'h080);
      run_txn(5'd22, 8'h80, 8'hFF, 0);
      check_val("spec_minneg_mod", {23'd0, last_err_s, last_res_s}, 32'h000);

      // Backpressure: held ADD result, ignored illegal op, then illegal accepted on release.
      op = 5'd18; a = 8'd3; b = 8'd4; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      op = 5'd25; a = 8'h12; b = 8'h34;
      for (int h = 0; h < 5; h++) begin
         check_val("bp_valid", {31'd0, bus_u.out_valid}, 32'd1);
         check_val("bp_result", {24'd0, bus_u.result}, 32'd7);
         check_val("bp_ready", {31'd0, bus_u.in_ready}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check_val("bp_release_ready", {31'd0, bus_u.in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check_val("bp_illegal", {23'd0, bus_u.err, bus_u.result}, 32'h100);
      check_val("bp_illegal_valid", {31'd0, bus_u.out_valid}, 32'd1);
      @(negedge clk);
      check_val("bp_drained", {31'd0, bus_u.out_valid}, 32'd0);

      // Reset in the middle of a division drops it.
      op = 5'd21; a = 8'd200; b = 8'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("midrst_in_ready", {31'd0, bus_u.in_ready}, 32'd0);
      repeat (3) @(negedge clk);
      check_val("midrst_outputs", {22'd0, bus_u.out_valid, bus_u.err, bus_u.result}, 32'd0);
      rst_n = 1'b1;
      #1;
      check_val("midrst_ready", {31'd0, bus_u.in_ready}, 32'd1);
      repeat (10) @(negedge clk);
      check_val("midrst_no_result", {31'd0, bus_u.out_valid | bus_s.out_valid}, 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         r_op = 5'($urandom_range(0, 31));
         r_a  = 8'($urandom);
         r_b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         if ((r_op == 5'd21 || r_op == 5'd22) && $urandom_range(0, 7) == 0) begin
            r_a = 8'h80;
            r_b = 8'hFF;
         end
         if ((r_op >= 5'd4 && r_op <= 5'd7) && $urandom_range(0, 1) == 0) begin
            r_b = 8'($urandom_range(0, 10));
         end
         run_txn(r_op, r_a, r_b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
